// File: rtl/vproc_pkg.sv
// Shared vproc types: per-beat store tag and result write-queue entry.
package vproc_pkg;

  typedef struct packed {
    logic shift;  // beat carries a store
    logic vreg;   // destination is a vector register
  } store_info;

  // Entry id width is fixed here so the entry can stay a package-level packed type.
  localparam int unsigned RES_ID_W = 3;

  // Data and byte enables stay out of the entry because their width is a module parameter.
  typedef struct packed {
    store_info           store;
    logic [4:0]          addr;
    logic                last;
    logic [RES_ID_W-1:0] id;
  } res_wr_entry;

  function automatic logic [31:0] vreg_onehot(input logic [4:0] addr);
    return 32'b1 << addr;
  endfunction

endpackage

// File: rtl/vproc_res_fifo.sv
// Generic FIFO with extended pointers. Head is visible combinationally, push-to-head latency 1.
// Pushes while full and pops while empty are ignored; count/full/empty are registered-state only.
module vproc_res_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     sync_rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: nothing reads an entry before it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem[rptr[AW-1:0]];
  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count_o = wptr - rptr;

endmodule

// File: rtl/vproc_result_wr_queue.sv
// Buffers unit result beats and drains them in order into one VRF write port; push-to-write latency 1
// (0 with VPROC_RES_BYPASS_EN on an empty buffer). res_ready_o drops only when the buffer is full.
module vproc_result_wr_queue
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W    = 128,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned ID_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_i,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  store_info             res_store_i,
  input  logic [4:0]            res_addr_i,
  input  logic [VREG_W-1:0]     res_data_i,
  input  logic [VREG_W/8-1:0]   res_be_i,
  input  logic                  res_last_i,
  input  logic [ID_W-1:0]       res_id_i,
  output logic                  vreg_wr_req_o,
  input  logic                  vreg_wr_gnt_i,
  output logic [4:0]            vreg_wr_addr_o,
  output logic [VREG_W/8-1:0]   vreg_wr_be_o,
  output logic [VREG_W-1:0]     vreg_wr_data_o,
  output logic [31:0]           hazard_clr_o,
  output logic                  done_valid_o,
  output logic [ID_W-1:0]       done_id_o
);

  localparam int unsigned BE_W    = VREG_W / 8;
  localparam int unsigned ENT_W   = $bits(res_wr_entry);
  localparam int unsigned FIFO_W  = ENT_W + VREG_W + BE_W;
  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;

  res_wr_entry        in_entry, head_entry, sel_entry;
  logic [VREG_W-1:0]  head_data, sel_data;
  logic [BE_W-1:0]    head_be, sel_be;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic               fifo_push, fifo_pop;
  logic               sel_vld, byp_hit, retire, wr_req;

  assign in_entry = '{store: res_store_i, addr: res_addr_i, last: res_last_i,
                      id: RES_ID_W'(res_id_i)};

  vproc_res_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .sync_rst_i (sync_rst_i),
    .push_i     (fifo_push),
    .wdata_i    ({in_entry, res_data_i, res_be_i}),
    .pop_i      (fifo_pop),
    .rdata_o    ({head_entry, head_data, head_be}),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign res_ready_o = (fifo_count < CNT_W'(BUF_DEPTH));

  // Select the beat presented to the write port: buffer head, or the incoming beat when bypassing.
  always_comb begin
    sel_vld   = 1'b0;
    byp_hit   = 1'b0;
    sel_entry = head_entry;
    sel_data  = head_data;
    sel_be    = head_be;
    if (!fifo_empty) begin
      sel_vld = 1'b1;
    end
`ifdef VPROC_RES_BYPASS_EN
    else if (res_valid_i && res_store_i.shift && res_store_i.vreg) begin
      byp_hit   = 1'b1;
      sel_vld   = 1'b1;
      sel_entry = in_entry;
      sel_data  = res_data_i;
      sel_be    = res_be_i;
    end
`endif
  end

  // Nothing leaves during reset, so discarded beats never produce pulses.
  assign wr_req = sel_vld & sel_entry.store.vreg & ~sync_rst_i;
  assign retire = sel_vld & ~sync_rst_i & (~sel_entry.store.vreg | vreg_wr_gnt_i);

  assign fifo_pop  = retire & ~byp_hit;
  assign fifo_push = res_valid_i & res_ready_o & res_store_i.shift & ~fifo_full
                   & ~(byp_hit & vreg_wr_gnt_i);

  assign vreg_wr_req_o  = wr_req;
  assign vreg_wr_addr_o = wr_req ? sel_entry.addr : 5'd0;
  assign vreg_wr_data_o = wr_req ? sel_data : '0;
  assign vreg_wr_be_o   = wr_req ? sel_be : '0;

  assign done_valid_o = retire & sel_entry.last;
  assign done_id_o    = done_valid_o ? ID_W'(sel_entry.id) : '0;
  assign hazard_clr_o = (retire & sel_entry.last & sel_entry.store.vreg)
                      ? vreg_onehot(sel_entry.addr) : 32'd0;

endmodule
